// File: rtl/sobel_bus_arbiter.sv
// sobel_bus_arbiter: round-robin arbiter sharing one Avalon-MM master between Sobel fetch (rd) and write-out (wr).
// Define SOBEL_ARB_TIMEOUT_EN to abort a transfer stalled for TIMEOUT_CYCLES waitrequest cycles (ack with err).
module sobel_bus_arbiter #(
    parameter int ADDR_W         = 32,
    parameter int DATA_W         = 32,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              master_read,
    output logic              master_write,
    output logic [ADDR_W-1:0] master_addr,
    output logic [DATA_W-1:0] master_writedata,
    input  logic [DATA_W-1:0] master_readdata,
    input  logic              master_waitrequest,
    output logic              busy,
    output logic              err
);
    // One-hot with split completion states so every strobe/ack output is a plain flop bit.
    typedef enum logic [4:0] {
        IDLE    = 5'b00001,
        RD      = 5'b00010,
        WR      = 5'b00100,
        RD_DONE = 5'b01000,
        WR_DONE = 5'b10000
    } state_t;

    state_t state, state_nxt;
    logic   last_wr;
    logic   grant_rd, grant_wr, xfer, finish, tmo;

    assign xfer     = state[1] | state[2];
    assign grant_rd = rd_req && (!wr_req || last_wr);
    assign grant_wr = wr_req && (!rd_req || !last_wr);
    assign finish   = !master_waitrequest || tmo;

`ifdef SOBEL_ARB_TIMEOUT_EN
    logic [7:0] wait_cnt;
    assign tmo = xfer && master_waitrequest && (wait_cnt == 8'(TIMEOUT_CYCLES - 1));
    always_ff @(posedge clk)
        if (rst || !xfer || finish) wait_cnt <= '0;
        else wait_cnt <= wait_cnt + 8'd1;
`else
    logic unused_cfg;
    assign unused_cfg = ^8'(TIMEOUT_CYCLES);
    assign tmo = 1'b0;
`endif

    always_ff @(posedge clk)
        state <= rst ? IDLE : state_nxt;

    always_comb begin
        state_nxt = IDLE;
        if (state == IDLE) state_nxt = grant_rd ? RD : grant_wr ? WR : IDLE;
        else if (xfer) state_nxt = finish ? (state == RD ? RD_DONE : WR_DONE) : state;
    end

    always_comb begin
        master_read  = state[1];
        master_write = state[2];
        rd_ack       = state[3];
        wr_ack       = state[4];
        busy         = !state[0];
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last_wr          <= 1'b1;
            master_addr      <= '0;
            master_writedata <= '0;
            rd_data          <= '0;
            err              <= 1'b0;
        end else begin
            err <= tmo;
            if (state == IDLE && grant_rd) begin
                last_wr     <= 1'b0;
                master_addr <= rd_addr;
            end else if (state == IDLE && grant_wr) begin
                last_wr          <= 1'b1;
                master_addr      <= wr_addr;
                master_writedata <= wr_data;
            end
            if (state == RD && finish) rd_data <= tmo ? '0 : master_readdata;
        end
    end
endmodule

// File: tb/tb_sobel_bus_arbiter.sv
// tb_sobel_bus_arbiter: directed scenarios plus randomized traffic against a transaction-level schedule model.
module tb_sobel_bus_arbiter;
    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        rd_req = 1'b0, wr_req = 1'b0;
    logic [31:0] rd_addr = '0, wr_addr = '0, wr_data = '0;
    logic        rd_ack, wr_ack, master_read, master_write, busy, err;
    logic [31:0] rd_data, master_addr, master_writedata;
    logic [31:0] master_readdata = '0;
    logic        master_waitrequest = 1'b0;
    logic [5:0]  ctrl;
    int          checks = 0;
    int          errors = 0;

    sobel_bus_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(4)) dut (
        .clk(clk), .rst(rst),
        .rd_req(rd_req), .rd_addr(rd_addr), .rd_ack(rd_ack), .rd_data(rd_data),
        .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_ack(wr_ack),
        .master_read(master_read), .master_write(master_write), .master_addr(master_addr),
        .master_writedata(master_writedata), .master_readdata(master_readdata),
        .master_waitrequest(master_waitrequest), .busy(busy), .err(err)
    );

    always #5 clk = ~clk;
    assign ctrl = {master_read, master_write, rd_ack, wr_ack, busy, err};

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // ctrl = {read, write, rd_ack, wr_ack, busy, err}
    localparam logic [5:0] C_IDLE = 6'b000000, C_RD = 6'b100010, C_WR = 6'b010010;
    localparam logic [5:0] C_RACK = 6'b001010, C_WACK = 6'b000110;

    logic        strobe, ack, own_wr, prev_wr, active;
    logic [31:0] exp_rd_data, pend_rd_data;
    int          idle_from, s_beg, s_end, nw;

    initial begin
        tick();
        tick();
        check("reset_ctrl", ctrl, C_IDLE);
        check("reset_rd_data", rd_data, 0);
        check("reset_addr", master_addr, 0);
        check("reset_wdata", master_writedata, 0);
        rst = 1'b0;

        // single read, then req lingering through the ack cycle
        rd_req = 1'b1; rd_addr = 32'h100; master_readdata = 32'hDEADBEEF;
        tick();
        check("t1_strobe", ctrl, C_RD);
        check("t1_addr", master_addr, 32'h100);
        tick();
        check("t1_ack", ctrl, C_RACK);
        check("t1_data", rd_data, 32'hDEADBEEF);
        tick();
        check("t4_idle", ctrl, C_IDLE);
        rd_req = 1'b0;
        tick();
        check("t4_no_reissue", ctrl, C_IDLE);
        tick();
        check("t4_no_reissue2", ctrl, C_IDLE);

        // write stalled for 3 cycles
        wr_req = 1'b1; wr_addr = 32'h200; wr_data = 32'h55; master_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t2_strobe", ctrl, C_WR);
            check("t2_addr", master_addr, 32'h200);
            check("t2_wdata", master_writedata, 32'h55);
            master_waitrequest = (i < 3);
            tick();
        end
        check("t2_ack", ctrl, C_WACK);
        wr_req = 1'b0;
        tick();
        check("t2_idle", ctrl, C_IDLE);

        // both requesters held continuously after reset
        rst = 1'b1;
        tick();
        rst = 1'b0; rd_req = 1'b1; wr_req = 1'b1;
        rd_addr = 32'h300; wr_addr = 32'h400; wr_data = 32'hAA; master_readdata = 32'h12345678;
        for (int k = 1; k <= 12; k++) begin
            tick();
            if ((k - 1) % 3 == 0) begin
                check("t3_strobe", ctrl, (((k - 1) / 3) % 2 == 0) ? C_RD : C_WR);
                check("t3_addr", master_addr, (((k - 1) / 3) % 2 == 0) ? 32'h300 : 32'h400);
            end else if ((k - 1) % 3 == 1) begin
                check("t3_ack", ctrl, (((k - 1) / 3) % 2 == 0) ? C_RACK : C_WACK);
            end else begin
                check("t3_gap", ctrl, C_IDLE);
            end
        end
        check("t3_rd_data", rd_data, 32'h12345678);
        rd_req = 1'b0; wr_req = 1'b0;
        tick();

`ifdef SOBEL_ARB_TIMEOUT_EN
        rd_req = 1'b1; rd_addr = 32'h600; master_readdata = 32'hFFFF; master_waitrequest = 1'b1;
        tick();
        for (int i = 0; i < 4; i++) begin
            check("t6_strobe", ctrl, C_RD);
            tick();
        end
        check("t6_ack_err", ctrl, C_RACK | 6'b000001);
        check("t6_rd_data", rd_data, 0);
        rd_req = 1'b0; master_waitrequest = 1'b0;
        tick();
        wr_req = 1'b1; wr_addr = 32'h700;
        tick();
        check("t6_next_strobe", ctrl, C_WR);
        tick();
        check("t6_next_ack", ctrl, C_WACK);
        wr_req = 1'b0;
        tick();
`endif

        // reset in the middle of a stalled write
        wr_req = 1'b1; wr_addr = 32'h500; master_waitrequest = 1'b1;
        tick();
        check("t5_strobe", ctrl, C_WR);
        rst = 1'b1;
        tick();
        check("t5_ctrl", ctrl, C_IDLE);
        check("t5_addr", master_addr, 0);
        check("t5_rd_data", rd_data, 0);
        rst = 1'b0; wr_req = 1'b0; master_waitrequest = 1'b0;
        tick();
        check("t5_no_ack", ctrl, C_IDLE);
        tick();
        check("t5_no_ack2", ctrl, C_IDLE);

        // randomized traffic: each grant schedules its strobe window and ack from a chosen wait count
        rst = 1'b1;
        tick();
        rst = 1'b0;
        prev_wr = 1'b1; active = 1'b0; own_wr = 1'b0; idle_from = 0; s_beg = 0; s_end = 0;
        exp_rd_data = '0; pend_rd_data = '0;
        for (int c = 0; c < 2000; c++) begin
            strobe = active && c >= s_beg && c <= s_end;
            ack    = active && c == s_end + 1;
            if (ack && !own_wr) exp_rd_data = pend_rd_data;
            check("rnd_ctrl", ctrl, {strobe && !own_wr, strobe && own_wr, ack && !own_wr, ack && own_wr, strobe || ack, 1'b0});
            check("rnd_rd_data", rd_data, exp_rd_data);
            if (strobe) check("rnd_addr", master_addr, own_wr ? wr_addr : rd_addr);
            if (strobe && own_wr) check("rnd_wdata", master_writedata, wr_data);
            if (ack) begin
                if (own_wr) wr_req = 1'b0;
                else rd_req = 1'b0;
                active = 1'b0;
            end
            if (!rd_req && $urandom_range(0, 2) == 0) begin
                rd_req = 1'b1; rd_addr = $urandom;
            end
            if (!wr_req && $urandom_range(0, 2) == 0) begin
                wr_req = 1'b1; wr_addr = $urandom; wr_data = $urandom;
            end
            master_readdata    = $urandom;
            master_waitrequest = strobe ? (c < s_end) : 1'($urandom_range(0, 1));
            if (strobe && c == s_end && !own_wr) pend_rd_data = master_readdata;
            if (c >= idle_from && (rd_req || wr_req)) begin
                own_wr    = !(rd_req && (!wr_req || prev_wr));
                prev_wr   = own_wr;
                nw        = $urandom_range(0, 3);
                s_beg     = c + 1;
                s_end     = c + 1 + nw;
                idle_from = s_end + 2;
                active    = 1'b1;
            end
            tick();
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
